// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the RV32I program counter, issues one instruction
// memory request at a time and hands fetched instructions to decode.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    output logic        misalign_fault
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic [XLEN-1:0]   req_pc, req_pc_d;
    logic              kill, kill_d;
    logic              imem_req_d;
    logic [XLEN-1:0]   imem_addr_d;
    logic              if_valid_d;
    logic [XLEN-1:0]   if_instr_d;
    logic [XLEN-1:0]   if_pc_d;
    logic [XLEN-1:0]   if_pcplus4_d;
    logic              misalign_fault_d;
    logic              redir;
    logic              redir_bad;

    // Redirect is live everywhere but FAULT; a misaligned target is fatal.
    assign redir     = redirect_valid && (state != FAULT);
    assign redir_bad = redir && (redirect_target[1:0] != 2'b00);

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d          = state;
        pc_d             = pc;
        req_pc_d         = req_pc;
        kill_d           = kill;
        imem_req_d       = imem_req;
        imem_addr_d      = imem_addr;
        if_valid_d       = if_valid;
        if_instr_d       = if_instr;
        if_pc_d          = if_pc;
        if_pcplus4_d     = if_pcplus4;
        misalign_fault_d = misalign_fault;

        if (redir_bad) begin
            misalign_fault_d = 1'b1;
            state_d          = FAULT;
            if_valid_d       = 1'b0;
            if_instr_d       = NOP_INSTR;
            imem_req_d       = 1'b0;
            kill_d           = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir) begin
                        pc_d = redirect_target;
                    end else if (fetch_en) begin
                        state_d     = REQ;
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc;
                    end
                end
                REQ: begin
                    if (redir) begin
                        pc_d = redirect_target;
                        if (imem_gnt) begin
                            // Granted request is now stale; drop its response.
                            kill_d     = 1'b1;
                            state_d    = WAIT;
                            imem_req_d = 1'b0;
                        end else begin
                            imem_addr_d = redirect_target;
                        end
                    end else if (imem_gnt) begin
                        req_pc_d   = pc;
                        pc_d       = XLEN'(pc + 32'd4);
                        state_d    = WAIT;
                        imem_req_d = 1'b0;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        pc_d = redirect_target;
                        if (imem_rvalid) begin
                            kill_d      = 1'b0;
                            state_d     = REQ;
                            imem_req_d  = 1'b1;
                            imem_addr_d = redirect_target;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill) begin
                            kill_d = 1'b0;
                            if (fetch_en) begin
                                state_d     = REQ;
                                imem_req_d  = 1'b1;
                                imem_addr_d = pc;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            if_instr_d   = imem_rdata;
                            if_pc_d      = req_pc;
                            if_pcplus4_d = XLEN'(req_pc + 32'd4);
                            if_valid_d   = 1'b1;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redir) begin
                        // Flush wins over a same-cycle decode handshake.
                        if_valid_d  = 1'b0;
                        if_instr_d  = NOP_INSTR;
                        pc_d        = redirect_target;
                        state_d     = REQ;
                        imem_req_d  = 1'b1;
                        imem_addr_d = redirect_target;
                    end else if (if_ready) begin
                        if_valid_d = 1'b0;
                        if_instr_d = NOP_INSTR;
                        if (fetch_en) begin
                            state_d     = REQ;
                            imem_req_d  = 1'b1;
                            imem_addr_d = pc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            req_pc         <= RESET_PC;
            kill           <= 1'b0;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            if_valid       <= 1'b0;
            if_instr       <= NOP_INSTR;
            if_pc          <= '0;
            if_pcplus4     <= '0;
            misalign_fault <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            req_pc         <= req_pc_d;
            kill           <= kill_d;
            imem_req       <= imem_req_d;
            imem_addr      <= imem_addr_d;
            if_valid       <= if_valid_d;
            if_instr       <= if_instr_d;
            if_pc          <= if_pc_d;
            if_pcplus4     <= if_pcplus4_d;
            misalign_fault <= misalign_fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed testbench for fetch_pc_sequencer with a small instruction memory model.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pcplus4;
    logic        misalign_fault;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int rdelay = 0;

    fetch_pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pcplus4      (if_pcplus4),
        .misalign_fault  (misalign_fault)
    );

    // Instruction memory contents.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (imem_req !== 1'b1) check({tag, "_req_timeout"}, 32'(imem_req), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (if_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (if_valid !== 1'b1) check({tag, "_valid_timeout"}, 32'(if_valid), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and count of cycles with if_valid high.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (if_valid === 1'b1) vcnt++;
        end
    end

    // Memory: grants immediately, responds rdelay cycles after the earliest slot.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_gnt = imem_req;
            if (imem_req === 1'b1) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = rdelay;
            end
        end
    end

    initial begin
        int prev;
        int v0;
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; if_ready = 1'b0;
        step(); step();

        // Reset values
        check("rst_req",    32'(imem_req), 32'd0);
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_valid",  32'(if_valid), 32'd0);
        check("rst_instr",  if_instr, 32'h0000_0013);
        check("rst_pc",     if_pc, 32'h0);
        check("rst_pcp4",   if_pcplus4, 32'h0);
        check("rst_fault",  32'(misalign_fault), 32'd0);

        // Sequential fetch, one instruction per 3 cycles
        rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_req("seq");
            check("seq_addr", imem_addr, 32'(4 * i));
            wait_valid("seq");
            check("seq_pc",    if_pc, 32'(4 * i));
            check("seq_pcp4",  if_pcplus4, 32'(4 * i + 4));
            check("seq_instr", if_instr, instr_of(32'(4 * i)));
            if (i > 0) check("seq_period", 32'(cyc - prev), 32'd3);
            prev = cyc;
        end

        // Backpressure on PC 0x4
        do_reset();
        wait_valid("bp0");
        check("bp_pc0", if_pc, 32'h0);
        step();
        if_ready = 1'b0;
        wait_valid("bp");
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 32'(if_valid), 32'd1);
            check("bp_instr", if_instr, 32'h0050_0093);
            check("bp_pc",    if_pc, 32'h4);
            check("bp_req",   32'(imem_req), 32'd0);
            step();
        end
        if_ready = 1'b1;
        rdelay   = 3;
        step();
        check("bp_release_valid", 32'(if_valid), 32'd0);
        wait_req("bp_next");
        check("bp_next_addr", imem_addr, 32'h8);

        // Redirect during WAIT with a slow response
        step();
        v0 = vcnt;
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        rdelay = 0;
        check("rw_valid", 32'(if_valid), 32'd0);
        wait_req("rw");
        check("rw_addr",     imem_addr, 32'h100);
        check("rw_no_valid", 32'(vcnt - v0), 32'd0);
        wait_valid("rw");
        check("rw_pc",    if_pc, 32'h100);
        check("rw_pcp4",  if_pcplus4, 32'h104);
        check("rw_instr", if_instr, instr_of(32'h100));

        // Redirect from HOLD to the top of the address space, then wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wr_flush_valid", 32'(if_valid), 32'd0);
        check("wr_req",  32'(imem_req), 32'd1);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wr");
        check("wr_pc",   if_pc, 32'hFFFF_FFFC);
        check("wr_pcp4", if_pcplus4, 32'h0);
        wait_req("wr_next");
        check("wr_next_addr", imem_addr, 32'h0);

        // Misaligned redirect is sticky until reset
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("mis_fault", 32'(misalign_fault), 32'd1);
            check("mis_req",   32'(imem_req), 32'd0);
            check("mis_valid", 32'(if_valid), 32'd0);
            step();
        end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        check("mis_stuck_fault", 32'(misalign_fault), 32'd1);
        check("mis_stuck_req",   32'(imem_req), 32'd0);

        // Asynchronous reset in the middle of WAIT
        do_reset();
        fetch_en = 1'b0;
        check("ar_fault_clr", 32'(misalign_fault), 32'd0);
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        fetch_en = 1'b1;
        wait_req("ar0");
        check("ar_addr0", imem_addr, 32'h200);
        wait_valid("ar0");
        check("ar_pc0", if_pc, 32'h200);
        rdelay = 2;
        wait_req("ar1");
        fetch_en = 1'b0;
        step();
        check("ar_pre_addr", imem_addr, 32'h204);
        #2 rst = 1'b1;
        #1;
        check("ar_req",   32'(imem_req), 32'd0);
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_pc",    if_pc, 32'h0);
        check("ar_pcp4",  if_pcplus4, 32'h0);
        check("ar_instr", if_instr, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;
        rdelay = 0;
        v0 = vcnt;
        step();
        step();
        check("ar_ign_valid", 32'(vcnt - v0), 32'd0);
        check("ar_ign_req",   32'(imem_req), 32'd0);
        fetch_en = 1'b1;
        wait_req("ar2");
        check("ar_first_addr", imem_addr, 32'h0);
        wait_valid("ar2");
        check("ar_first_pc", if_pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the architectural program counter for the RV32I front end and sequences instruction fetch. It issues one request at a time to instruction memory through a request/grant/response handshake, and presents the returned instruction with its PC and PC+4 to decode through a valid/ready handshake. It handles branch/jump redirects, including squashing in-flight responses, and flags misaligned redirect targets. It sits between the PC+4 adder path, instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on if_instr while nothing valid (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
fetch_en  in  1  allow new fetches to start.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_target  in  32  new PC for redirect.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address, word aligned.
imem_gnt  in  1  memory accepts request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  fetched instruction.
if_valid  out  1  instruction available to decode.
if_ready  in  1  decode accepts instruction.
if_instr  out  32  instruction to decode.
if_pc  out  32  PC of if_instr.
if_pcplus4  out  32  if_pc + 4.
misalign_fault  out  1  sticky: redirect target not word aligned.

Behaviour:
- One clock, rst is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: pc=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pcplus4=0, misalign_fault=0.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: outputs quiet. If fetch_en=1, go to REQ next cycle.
- REQ:
  - imem_req=1 and imem_addr=pc, driven from registers and held stable until grant.
  - On imem_gnt=1: req_pc<=pc, pc<=pc+4 (32-bit, wraps mod 2^32), go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid=1 with kill=0: if_instr<=imem_rdata, if_pc<=req_pc, if_pcplus4<=req_pc+4, if_valid<=1, go to HOLD.
  - On imem_rvalid=1 with kill=1: discard the data, kill<=0, go to REQ if fetch_en=1, else IDLE.
  - imem_rvalid is ignored outside WAIT.
- HOLD:
  - if_valid=1 and all if_* outputs held stable until if_ready=1.
  - On the handshake: if_valid<=0, if_instr<=NOP_INSTR, go to REQ if fetch_en=1, else IDLE.
- Latency: a grant in cycle n allows rvalid earliest in n+1, and if_valid rises the cycle after rvalid. With single-cycle memory and if_ready tied high, throughput is 1 instruction per 3 cycles.
- Redirect has the highest priority and is evaluated every cycle except in FAULT.
  - Misaligned target (redirect_target[1:0]!=0): misalign_fault<=1, go to FAULT, if_valid<=0, imem_req<=0. FAULT is terminal until rst.
  - IDLE: pc<=target, stay in IDLE.
  - REQ without gnt: pc<=target, stay in REQ; the next cycle imem_addr=target. The request may be retargeted only here.
  - REQ with gnt in the same cycle: pc<=target, kill<=1, go to WAIT. That response is dropped.
  - WAIT with no rvalid: pc<=target, kill<=1.
  - WAIT with rvalid in the same cycle: drop the data, pc<=target, go to REQ. if_valid stays 0.
  - HOLD: if_valid<=0, drop the buffered instruction, pc<=target, go to REQ. This applies even if if_ready=1 in the same cycle; decode must ignore a fetch it is flushing.
- fetch_en is sampled only in IDLE and at WAIT-kill/HOLD exit. Deasserting it never aborts an in-flight request.
- Reset mid-operation: all state returns to reset values immediately. Any later imem_rvalid is ignored because the state is IDLE.

Test Plan:
- Sequential fetch: rst pulse, fetch_en=1, 1-cycle memory, if_ready=1 -> imem_addr 0x0,0x4,0x8 and if_pc/if_pcplus4 = 0x0/0x4, 0x4/0x8, 0x8/0xC, one if_valid pulse per 3 cycles.
- Backpressure: if_ready=0 for 4 cycles with instr 0x00500093 at PC 0x4 -> if_valid, if_instr, if_pc held stable, no imem_req until if_ready=1.
- Redirect in WAIT: rvalid delayed 3 cycles, redirect_target=0x100 during WAIT -> late rdata discarded, next imem_addr=0x100, next if_pc=0x100.
- Wrap-around: redirect to 0xFFFFFFFC, fetch -> if_pcplus4=0x0, next imem_addr=0x0.
- Misaligned redirect: redirect_target=0x102 -> misalign_fault=1, imem_req=0 and if_valid=0 permanently until rst.
- Async reset mid-WAIT: assert rst between clock edges -> outputs reset immediately; rvalid after release is ignored; first fetch is at RESET_PC.
